// File: rtl/grant_fsm_pkg.sv
// Shared types and sizing helpers for the multi-channel grant state machine.
package grant_fsm_pkg;

    typedef enum logic [1:0] {
        CH_IDLE       = 2'd0,
        CH_REQUESTING = 2'd1,
        CH_GRANT      = 2'd2,
        CH_REVOKE     = 2'd3
    } ty_CH_STATE;

    // A zero-width counter is not legal, so HOLD_MAX=0 still yields one bit.
    function automatic int unsigned hold_cnt_width(input int unsigned hold_max);
        int unsigned w;
        w = $clog2(hold_max + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/grant_fsm_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after i_ptr, wrapping.
module rr_arbiter
    import grant_fsm_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned PW   = idx_width(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [N_CH-1:0] o_winner,
    output logic            o_valid
);

    logic [N_CH-1:0] w_mask;
    logic [N_CH-1:0] w_hi;
    logic [N_CH-1:0] w_src;
    logic            w_found;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_mask[i] = (i >= 32'(i_ptr));
        end
    end

    assign w_hi    = i_req & w_mask;
    // Requests at/after ptr take precedence; otherwise wrap to the lowest index.
    assign w_src   = (|w_hi) ? w_hi : i_req;
    assign o_valid = |i_req;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_src[i] && !w_found) begin
                o_winner[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_fsm.sv
// N_CH per-channel request/grant/revoke FSMs sharing one resource via round-robin arbitration,
// with an optional hold timeout that forces a revoke.
module grant_fsm
    import grant_fsm_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                    i_ck,
    input  logic                    i_srst,
    input  logic [N_CH-1:0]         i_req,
    input  logic [N_CH-1:0]         i_done,
    input  logic [N_CH-1:0]         i_revokeAck,
    output logic [N_CH-1:0]         o_grant,
    output logic [N_CH-1:0]         o_revoke,
    output logic [$clog2(N_CH)-1:0] o_grantIdx,
    output logic                    o_timeout,
    output logic                    o_busy
);

    localparam int unsigned IW = $clog2(N_CH);
    localparam int unsigned CW = hold_cnt_width(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    logic [N_CH-1:0] w_arb_req;
    logic [N_CH-1:0] w_win;
    logic            w_arb_valid;
    logic [N_CH-1:0] w_active;
    logic [N_CH-1:0] w_in_grant;
    logic [N_CH-1:0] w_grant_now;
    logic [N_CH-1:0] w_grant_nx;
    logic [N_CH-1:0] w_revoke_nx;
    logic [N_CH-1:0] w_tmo_vec;
    logic            w_arb_en;
    logic            w_hold_last;
    logic [IW-1:0]   w_win_idx;
    logic [IW-1:0]   w_idx_next;

    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [N_CH-1:0] r_grant;
    logic [N_CH-1:0] r_revoke;
    logic [IW-1:0]   r_idx;
    logic            r_timeout;
    logic            r_busy;

    rr_arbiter #(
        .N_CH (N_CH),
        .PW   (IW)
    ) u_arb (
        .i_req    (w_arb_req),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_valid  (w_arb_valid)
    );

    // Arbitrate only on a free resource, judged from registered state.
    assign w_arb_en    = !(|w_active) && w_arb_valid;
    assign w_grant_now = w_arb_en ? w_win : '0;
    assign w_hold_last = (HOLD_MAX != 0) && (r_cnt == HOLD_LAST);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ty_CH_STATE r_state;
        ty_CH_STATE w_state_next;
        logic       w_tmo;

        always_comb begin
            w_state_next = r_state;
            w_tmo        = 1'b0;
            case (r_state)
                CH_IDLE: begin
                    if (i_req[c]) w_state_next = CH_REQUESTING;
                end
                CH_REQUESTING: begin
                    if (!i_req[c])          w_state_next = CH_IDLE;
                    else if (w_grant_now[c]) w_state_next = CH_GRANT;
                end
                CH_GRANT: begin
                    if (i_done[c]) begin
                        w_state_next = CH_REVOKE;
                    end else if (w_hold_last) begin
                        w_state_next = CH_REVOKE;
                        w_tmo        = 1'b1;
                    end
                end
                CH_REVOKE: begin
                    if (i_revokeAck[c]) w_state_next = CH_IDLE;
                end
                default: w_state_next = CH_IDLE;
            endcase
        end

        always_ff @(posedge i_ck) begin
            if (i_srst) r_state <= CH_IDLE;
            else        r_state <= w_state_next;
        end

        assign w_arb_req[c]   = (r_state == CH_REQUESTING) && i_req[c];
        assign w_in_grant[c]  = (r_state == CH_GRANT);
        assign w_active[c]    = (r_state == CH_GRANT) || (r_state == CH_REVOKE);
        assign w_grant_nx[c]  = (w_state_next == CH_GRANT);
        assign w_revoke_nx[c] = (w_state_next == CH_REVOKE);
        assign w_tmo_vec[c]   = w_tmo;
    end

    always_comb begin
        w_win_idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_win[i]) w_win_idx = IW'(i);
        end
    end

    always_comb begin
        w_idx_next = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_grant_nx[i] || w_revoke_nx[i]) w_idx_next = IW'(i);
        end
    end

    always_ff @(posedge i_ck) begin
        if (i_srst) begin
            r_ptr <= '0;
        end else if (|w_grant_now) begin
            r_ptr <= (w_win_idx == IW'(N_CH - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

    always_ff @(posedge i_ck) begin
        if (i_srst) begin
            r_cnt <= '0;
        end else if (|w_grant_now) begin
            r_cnt <= '0;
        end else if ((|w_in_grant) && (HOLD_MAX != 0)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Outputs load the next-state decode, so they change with the state flops.
    always_ff @(posedge i_ck) begin
        if (i_srst) begin
            r_grant   <= '0;
            r_revoke  <= '0;
            r_idx     <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_grant   <= w_grant_nx;
            r_revoke  <= w_revoke_nx;
            r_idx     <= w_idx_next;
            r_timeout <= |w_tmo_vec;
            r_busy    <= |(w_grant_nx | w_revoke_nx);
        end
    end

    assign o_grant    = r_grant;
    assign o_revoke   = r_revoke;
    assign o_grantIdx = r_idx;
    assign o_timeout  = r_timeout;
    assign o_busy     = r_busy;

    a_one_owner: assert property (@(posedge i_ck) disable iff (i_srst) $onehot0(w_active));
    a_out_onehot: assert property (@(posedge i_ck) disable iff (i_srst)
                                   $onehot0(o_grant | o_revoke));

endmodule

// File: tb/tb_grant_fsm.sv
// Self-checking bench for grant_fsm: three instances (HOLD_MAX 4, 0, 3) share one stimulus set.
module tb_grant_fsm;

    logic       clk = 1'b0;
    logic       srst;
    logic [3:0] req, done, ack;

    logic [3:0] a_grant, a_revoke, b_grant, b_revoke, c_grant, c_revoke;
    logic [1:0] a_idx, b_idx, c_idx;
    logic       a_tmo, a_busy, b_tmo, b_busy, c_tmo, c_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    grant_fsm #(.N_CH(4), .HOLD_MAX(4)) u_dut (
        .i_ck(clk), .i_srst(srst), .i_req(req), .i_done(done), .i_revokeAck(ack),
        .o_grant(a_grant), .o_revoke(a_revoke), .o_grantIdx(a_idx),
        .o_timeout(a_tmo), .o_busy(a_busy)
    );

    grant_fsm #(.N_CH(4), .HOLD_MAX(0)) u_dut_nt (
        .i_ck(clk), .i_srst(srst), .i_req(req), .i_done(done), .i_revokeAck(ack),
        .o_grant(b_grant), .o_revoke(b_revoke), .o_grantIdx(b_idx),
        .o_timeout(b_tmo), .o_busy(b_busy)
    );

    grant_fsm #(.N_CH(4), .HOLD_MAX(3)) u_dut_h3 (
        .i_ck(clk), .i_srst(srst), .i_req(req), .i_done(done), .i_revokeAck(ack),
        .o_grant(c_grant), .o_revoke(c_revoke), .o_grantIdx(c_idx),
        .o_timeout(c_tmo), .o_busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0: reset taken, inputs driven now are sampled at the next edge.
    task automatic do_reset();
        srst = 1'b1; req = '0; done = '0; ack = '0;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_grant !== 4'b0) $display("FAIL reset_grant got %b want 0000", a_grant); else n_pass++;
        n_checks++; if (a_revoke !== 4'b0) $display("FAIL reset_revoke got %b want 0000", a_revoke); else n_pass++;
        n_checks++; if (a_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", a_idx); else n_pass++;
        n_checks++; if (a_tmo !== 1'b0) $display("FAIL reset_timeout got %b want 0", a_tmo); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else n_pass++;
    endtask

    task automatic test_single();
        int e;
        logic [3:0] oh;
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        n_checks++; if (a_grant !== 4'b0) $display("FAIL single_early got %b want 0000", a_grant); else n_pass++;
        tick();
        e  = exp_q.pop_front();
        oh = 4'b0001 << e;
        n_checks++; if (a_grant !== oh) $display("FAIL single_grant got %b want %b", a_grant, oh); else n_pass++;
        n_checks++; if (a_idx !== 2'(e)) $display("FAIL single_idx got %0d want %0d", a_idx, e); else n_pass++;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL single_busy got %b want 1", a_busy); else n_pass++;
        req = '0; done = 4'b0001;
        tick();
        n_checks++;
        if (a_grant !== 4'b0 || a_revoke !== 4'b0001)
            $display("FAIL single_release got grant=%b revoke=%b want 0000/0001", a_grant, a_revoke);
        else n_pass++;
        done = '0; ack = 4'b0001;
        tick();
        n_checks++;
        if (a_revoke !== 4'b0 || a_busy !== 1'b0)
            $display("FAIL single_ack got revoke=%b busy=%b want 0000/0", a_revoke, a_busy);
        else n_pass++;
        ack = '0;
    endtask

    task automatic test_round_robin();
        int e, last, w;
        logic [3:0] oh;
        do_reset();
        req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        last = 0;
        for (int i = 0; i < 5; i++) begin
            w = 0;
            while (a_grant === 4'b0 && w < 8) begin tick(); w++; end
            e  = exp_q.pop_front();
            oh = 4'b0001 << e;
            n_checks++;
            if (a_grant !== oh || a_idx !== 2'(e))
                $display("FAIL rr_order[%0d] got grant=%b idx=%0d want %b/%0d", i, a_grant, a_idx, oh, e);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (cyc - last != 3) $display("FAIL rr_gap[%0d] got %0d want 3", i, cyc - last);
                else n_pass++;
            end
            last = cyc;
            if (i == 4) req = '0;
            done = oh;
            tick();
            done = '0; ack = oh;
            tick();
            ack = '0;
            n_checks++;
            if (a_busy !== 1'b0) $display("FAIL rr_free[%0d] got busy=%b want 0", i, a_busy);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int w, n;
        do_reset();
        req = 4'b0001;
        w = 0;
        while (a_grant === 4'b0 && w < 8) begin tick(); w++; end
        req = '0;
        n = 0;
        while (a_grant[0] === 1'b1 && n < 20) begin n++; tick(); end
        n_checks++; if (n != 4) $display("FAIL tmo_hold got %0d want 4", n); else n_pass++;
        n_checks++;
        if (a_revoke !== 4'b0001 || a_tmo !== 1'b1)
            $display("FAIL tmo_pulse got revoke=%b tmo=%b want 0001/1", a_revoke, a_tmo);
        else n_pass++;
        tick();
        n_checks++;
        if (a_revoke !== 4'b0001 || a_tmo !== 1'b0)
            $display("FAIL tmo_single got revoke=%b tmo=%b want 0001/0", a_revoke, a_tmo);
        else n_pass++;
        ack = 4'b0001;
        tick();
        ack = '0;
    endtask

    task automatic test_no_timeout();
        int w, bad;
        do_reset();
        req = 4'b0001;
        w = 0;
        while (b_grant === 4'b0 && w < 8) begin tick(); w++; end
        req = '0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (b_grant !== 4'b0001 || b_revoke !== 4'b0 || b_tmo !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad != 0) $display("FAIL notmo_hold got %0d bad cycles want 0", bad); else n_pass++;
        done = 4'b0001;
        tick();
        done = '0;
        n_checks++;
        if (b_revoke !== 4'b0001 || b_tmo !== 1'b0)
            $display("FAIL notmo_release got revoke=%b tmo=%b want 0001/0", b_revoke, b_tmo);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        n_checks++; if (c_grant !== 4'b0001) $display("FAIL simul_grant got %b want 0001", c_grant); else n_pass++;
        req = '0;
        tick();
        tick();
        done = 4'b0001;
        tick();
        done = '0;
        n_checks++;
        if (c_grant !== 4'b0 || c_revoke !== 4'b0001 || c_tmo !== 1'b0)
            $display("FAIL simul_done got grant=%b revoke=%b tmo=%b want 0000/0001/0",
                     c_grant, c_revoke, c_tmo);
        else n_pass++;
        ack = 4'b0001;
        tick();
        ack = '0;
    endtask

    task automatic test_withdraw_stray();
        int seen;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0100; ack = 4'b0001;
        tick();
        n_checks++;
        if (a_grant !== 4'b0001 || a_revoke !== 4'b0)
            $display("FAIL stray_ack got grant=%b revoke=%b want 0001/0000", a_grant, a_revoke);
        else n_pass++;
        req = '0; ack = '0;
        tick();
        done = 4'b0001;
        tick();
        n_checks++; if (a_revoke !== 4'b0001) $display("FAIL wd_revoke got %b want 0001", a_revoke); else n_pass++;
        done = 4'b0100; ack = 4'b0001;
        tick();
        done = '0; ack = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_grant !== 4'b0 || a_busy !== 1'b0) seen++;
            tick();
        end
        n_checks++; if (seen != 0) $display("FAIL wd_never got %0d busy cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w, e;
        logic [3:0] oh;
        do_reset();
        req = 4'b1111;
        w = 0;
        while (a_grant === 4'b0 && w < 8) begin tick(); w++; end
        done = a_grant;
        tick();
        done = '0; ack = 4'b0001;
        tick();
        ack = '0;
        w = 0;
        while (a_grant === 4'b0 && w < 8) begin tick(); w++; end
        n_checks++; if (a_grant !== 4'b0010) $display("FAIL mid_ch1 got %b want 0010", a_grant); else n_pass++;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        n_checks++;
        if (a_grant !== 4'b0 || a_revoke !== 4'b0 || a_idx !== 2'd0 || a_tmo !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL mid_clear got grant=%b revoke=%b idx=%0d tmo=%b busy=%b want all 0",
                     a_grant, a_revoke, a_idx, a_tmo, a_busy);
        else n_pass++;
        exp_q.push_back(0);
        w = 0;
        while (a_grant === 4'b0 && w < 8) begin tick(); w++; end
        e  = exp_q.pop_front();
        oh = 4'b0001 << e;
        n_checks++; if (a_grant !== oh) $display("FAIL mid_ptr got %b want %b", a_grant, oh); else n_pass++;
        n_checks++; if (w != 2) $display("FAIL mid_latency got %0d want 2", w); else n_pass++;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_no_timeout();
        test_simultaneous();
        test_withdraw_stray();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
